if_prefetch_unit: RTL and testbench

Instruction prefetch front end of the ARM pipeline, sitting directly upstream of the IF pipeline register and standing in for the fetch stage's PC/instruction source. It owns the fetch PC, issues in-order requests to an instruction memory over a request/response handshake, and buffers returned words with their PC in a small FIFO. It presents one instruction per cycle to the IF register, honours downstream freeze, and discards all stale fetches on a taken branch.

---
 rtl/if_prefetch_unit.sv | 141 ++++++++++++++
 tb/tb_if_prefetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch front end: owns the fetch PC, issues in-order memory
// requests, and buffers returned words with their PC for the IF register.
module if_prefetch_unit #(
  parameter int unsigned           WORD_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_addr,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_WIDTH-1:0] fifo_addr_q [DEPTH];
  logic [WORD_WIDTH-1:0] fifo_addr_d [DEPTH];
  logic [WORD_WIDTH-1:0] fifo_word_q [DEPTH];
  logic [WORD_WIDTH-1:0] fifo_word_d [DEPTH];
  logic [WORD_WIDTH-1:0] tag_q [DEPTH];
  logic [WORD_WIDTH-1:0] tag_d [DEPTH];
  logic [PW-1:0]         fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [PW-1:0]         tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         discard_q, discard_d;

  logic [CW:0]           credit_used;
  logic [CW-1:0]         drain_left;
  logic                  accept, push, pop;

  assign credit_used = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign imem_req    = (state_q == FETCH) && (credit_used < DEPTH_C) && !branch_taken;
  assign imem_addr   = fetch_pc_q;
  assign valid       = (fifo_cnt_q != '0);
  assign pc          = valid ? fifo_addr_q[fifo_rd_q] + WORD_WIDTH'(4) : '0;
  assign instruction = valid ? fifo_word_q[fifo_rd_q] : '0;

  assign accept = imem_req && imem_ready;
  assign pop    = valid && !freeze;
  assign push   = (state_q == FETCH) && !branch_taken && imem_rvalid && (outst_q != '0);
  // A response arriving alongside the branch is already stale, so it is not counted.
  assign drain_left = (imem_rvalid && (outst_q != '0)) ? outst_q - CW'(1) : outst_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    fifo_addr_d = fifo_addr_q;
    fifo_word_d = fifo_word_q;
    tag_d       = tag_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;
    tag_rd_d    = tag_rd_q;
    tag_wr_d    = tag_wr_q;
    fifo_cnt_d  = fifo_cnt_q;
    outst_d     = outst_q;
    discard_d   = discard_q;

    if (branch_taken) begin
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      fifo_cnt_d = '0;
      tag_rd_d   = '0;
      tag_wr_d   = '0;
      fetch_pc_d = branch_addr & ~WORD_WIDTH'(3);
      outst_d    = drain_left;
      discard_d  = drain_left;
      state_d    = (drain_left != '0) ? DRAIN : FETCH;
    end else begin
      if (state_q == DRAIN) begin
        if (imem_rvalid && (discard_q != '0)) begin
          discard_d = discard_q - CW'(1);
          outst_d   = outst_q - CW'(1);
          if (discard_q == CW'(1)) state_d = FETCH;
        end
      end else begin
        if (accept) begin
          tag_d[tag_wr_q] = fetch_pc_q;
          tag_wr_d        = tag_wr_q + PW'(1);
          fetch_pc_d      = fetch_pc_q + WORD_WIDTH'(4);
        end
        if (push) begin
          fifo_addr_d[fifo_wr_q] = tag_q[tag_rd_q];
          fifo_word_d[fifo_wr_q] = imem_rdata;
          fifo_wr_d              = fifo_wr_q + PW'(1);
          tag_rd_d               = tag_rd_q + PW'(1);
        end
        outst_d = outst_q + CW'(accept) - CW'(push);
      end
      if (pop) fifo_rd_d = fifo_rd_q + PW'(1);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      fifo_cnt_q <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      fifo_cnt_q <= fifo_cnt_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  // Payload storage needs no reset: it is only observed through valid counts.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_word_q <= fifo_word_d;
    tag_q       <= tag_d;
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: a queue-based memory plus a reference model of
// the expected instruction stream, with one task per scenario.
`timescale 1ns/1ps
module tb_if_prefetch_unit;

  localparam int unsigned D   = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken, imem_ready, imem_rvalid;
  logic [31:0] branch_addr, imem_rdata;
  logic        imem_req, valid;
  logic [31:0] imem_addr, pc, instruction;

  always #5 clk = ~clk;

  if_prefetch_unit #(.WORD_WIDTH(32), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc(pc), .instruction(instruction), .valid(valid)
  );

  typedef struct packed { int due; logic [31:0] addr; } mem_t;
  typedef struct packed { logic [31:0] addr; logic stale; } fl_t;

  mem_t        mem_q[$];
  fl_t         infl[$];
  logic [31:0] exp_out[$];
  logic [31:0] mdl_pc;
  int          cyc;
  int          lat_min = 1, lat_max = 1;
  int          n_checks = 0, n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Requests allowed only when no stale fetch is pending and credit remains.
  function automatic logic exp_req();
    int stale_n = 0;
    foreach (infl[i]) if (infl[i].stale) stale_n++;
    return (stale_n == 0) && (infl.size() + exp_out.size() < int'(D)) && !branch_taken;
  endfunction

  // Memory drives at the falling edge; the model absorbs the cycle's events at +2.
  initial begin : env
    fl_t         fl;
    logic [31:0] drop;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    cyc         = 0;
    mdl_pc      = RPC;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_q[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      #2;
      if (rst !== 1'b1) begin
        mem_q.delete();
        infl.delete();
        exp_out.delete();
        mdl_pc = RPC;
      end else begin
        if (exp_out.size() > 0 && !freeze) drop = exp_out.pop_front();
        if (imem_rvalid) begin
          mem_q.delete(0);
          if (infl.size() > 0) begin
            fl = infl.pop_front();
            if (!fl.stale && !branch_taken) exp_out.push_back(fl.addr);
          end
        end
        if (branch_taken) begin
          exp_out.delete();
          foreach (infl[i]) infl[i].stale = 1'b1;
          mdl_pc = {branch_addr[31:2], 2'b00};
        end else if (imem_req && imem_ready) begin
          mem_q.push_back('{due: cyc + int'($urandom_range(lat_max, lat_min)), addr: imem_addr});
          infl.push_back('{addr: mdl_pc, stale: 1'b0});
          mdl_pc = mdl_pc + 32'd4;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
  endtask

  task automatic do_reset(input logic init_freeze);
    rst = 1'b0; freeze = init_freeze; branch_taken = 1'b0;
    branch_addr = '0; imem_ready = 1'b1;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; imem_ready = 1'b1;
    step(); step();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", pc); end
    n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", instruction); end
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== RPC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); end
  endtask

  task automatic test_stream();
    lat_min = 1; lat_max = 1;
    do_reset(1'b0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RPC);
    end
    step();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL stream_cycle1_valid: got %b want 0", valid); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++; if (valid !== 1'b1 || pc !== RPC + 32'(4*i + 4) || instruction !== mem_word(RPC + 32'(4*i))) begin
        n_fail++;
        $display("FAIL stream_out[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h", i, valid, pc,
                 instruction, RPC + 32'(4*i + 4), mem_word(RPC + 32'(4*i)));
      end
    end
  endtask

  task automatic test_freeze();
    lat_min = 1; lat_max = 1;
    do_reset(1'b1);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c >= 2) begin
        n_checks++; if (valid !== 1'b1 || pc !== RPC + 32'd4) begin
          n_fail++; $display("FAIL freeze_hold[%0d]: got v=%b pc=%h want v=1 pc=%h", c, valid, pc, RPC + 32'd4);
        end
      end
    end
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL freeze_full_req: got %b want 0", imem_req); end
    freeze = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      n_checks++; if (valid !== 1'b1 || pc !== RPC + 32'(4*j + 8) || instruction !== mem_word(RPC + 32'(4*j + 4))) begin
        n_fail++;
        $display("FAIL freeze_resume[%0d]: got v=%b pc=%h ins=%h want v=1 pc=%h", j, valid, pc, instruction,
                 RPC + 32'(4*j + 8));
      end
    end
  endtask

  task automatic test_branch_drain();
    logic seen = 1'b0;
    lat_min = 4; lat_max = 4;
    do_reset(1'b0);
    step(); step(); step();
    branch_taken = 1'b1; branch_addr = 32'h0000_0103;
    #0.5;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL branch_req_comb: got %b want 0", imem_req); end
    step();
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL branch_valid_next: got %b want 0", valid); end
    for (int k = 0; k < 20 && !seen; k++) begin
      if (imem_req === 1'b1) begin
        seen = 1'b1;
        n_checks++; if (k != 3 || imem_addr !== 32'h100) begin
          n_fail++; $display("FAIL branch_first_req: got k=%0d addr=%h want k=3 addr=00000100", k, imem_addr);
        end
      end else begin
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL branch_drain_valid[%0d]: got %b want 0", k, valid); end
        step();
      end
    end
    if (!seen) begin n_checks++; n_fail++; $display("FAIL branch_first_req: got none want request within 20 cycles"); end
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      if (valid === 1'b1) begin
        seen = 1'b1;
        n_checks++; if (pc !== 32'h104 || instruction !== mem_word(32'h100)) begin
          n_fail++; $display("FAIL branch_first_out: got pc=%h ins=%h want pc=00000104 ins=%h", pc, instruction, mem_word(32'h100));
        end
      end
    end
    if (!seen) begin n_checks++; n_fail++; $display("FAIL branch_first_out: got no valid want pc=00000104"); end
  endtask

  task automatic test_branch_resp_freeze();
    logic [31:0] target;
    logic        seen;
    for (int lat = 1; lat <= 2; lat++) begin
      lat_min = lat; lat_max = lat;
      do_reset(1'b0);
      repeat (4) step();
      n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL brf_pre_valid[lat%0d]: got %b want 1", lat, valid); end
      target = 32'h0000_2000 + 32'(lat * 64);
      branch_taken = 1'b1; branch_addr = target | 32'h2; freeze = 1'b1;
      step();
      freeze = 1'b0;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL brf_valid[lat%0d]: got %b want 0", lat, valid); end
      for (int k = 0; k < lat - 1; k++) begin
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL brf_drain_req[lat%0d]: got %b want 0", lat, imem_req); end
        step();
      end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== target) begin
        n_fail++; $display("FAIL brf_req[lat%0d]: got req=%b addr=%h want req=1 addr=%h", lat, imem_req, imem_addr, target);
      end
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        step();
        if (valid === 1'b1) begin
          seen = 1'b1;
          n_checks++; if (pc !== target + 32'd4) begin
            n_fail++; $display("FAIL brf_out[lat%0d]: got pc=%h want %h", lat, pc, target + 32'd4);
          end
        end
      end
      if (!seen) begin n_checks++; n_fail++; $display("FAIL brf_out[lat%0d]: got no valid want pc=%h", lat, target + 32'd4); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want_addr [3];
    want_addr[0] = 32'hFFFF_FFF8; want_addr[1] = 32'hFFFF_FFFC; want_addr[2] = 32'h0000_0000;
    lat_min = 1; lat_max = 1;
    do_reset(1'b0);
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFF9;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== want_addr[i]) begin
        n_fail++; $display("FAIL wrap_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, want_addr[i]);
      end
    end
    step();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h0 || instruction !== mem_word(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_out: got v=%b pc=%h ins=%h want v=1 pc=00000000 ins=%h", valid, pc, instruction,
                         mem_word(32'hFFFF_FFFC));
    end
    step();
    n_checks++; if (valid !== 1'b1 || pc !== 32'h4) begin
      n_fail++; $display("FAIL wrap_next: got v=%b pc=%h want v=1 pc=00000004", valid, pc);
    end
  endtask

  task automatic test_random(input logic with_branch, input int n_target, input int budget);
    int          accepts = 0;
    int          cycles = 0;
    logic        have_last = 1'b0;
    logic [31:0] last_pc = '0;
    lat_min = 1; lat_max = 3;
    do_reset(1'b0);
    while (cycles < budget && (with_branch || accepts < n_target)) begin
      n_checks++; if (valid !== (exp_out.size() != 0)) begin
        n_fail++; $display("FAIL rand_valid[c%0d]: got %b want %b", cycles, valid, exp_out.size() != 0);
      end
      if (exp_out.size() != 0) begin
        n_checks++; if (pc !== exp_out[0] + 32'd4 || instruction !== mem_word(exp_out[0])) begin
          n_fail++; $display("FAIL rand_head[c%0d]: got pc=%h ins=%h want pc=%h ins=%h", cycles, pc, instruction,
                             exp_out[0] + 32'd4, mem_word(exp_out[0]));
        end
      end
      n_checks++; if (imem_req !== exp_req()) begin
        n_fail++; $display("FAIL rand_req[c%0d]: got %b want %b", cycles, imem_req, exp_req());
      end
      if (imem_req === 1'b1) begin
        n_checks++; if (imem_addr !== mdl_pc) begin
          n_fail++; $display("FAIL rand_addr[c%0d]: got %h want %h", cycles, imem_addr, mdl_pc);
        end
      end
      n_checks++; if (infl.size() + exp_out.size() > int'(D)) begin
        n_fail++; $display("FAIL rand_credit[c%0d]: got %0d in use want <= %0d", cycles, infl.size() + exp_out.size(), D);
      end
      imem_ready = 1'($urandom_range(1, 0));
      freeze     = ($urandom_range(3, 0) == 0);
      if (with_branch && $urandom_range(19, 0) == 0) begin
        branch_taken = 1'b1;
        branch_addr  = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      end
      if (!with_branch && valid === 1'b1 && !freeze) begin
        if (have_last) begin
          n_checks++; if (pc !== last_pc + 32'd4) begin
            n_fail++; $display("FAIL rand_ascend[c%0d]: got pc=%h want %h", cycles, pc, last_pc + 32'd4);
          end
        end
        have_last = 1'b1;
        last_pc   = pc;
      end
      if (imem_req === 1'b1 && imem_ready && !branch_taken) accepts++;
      step();
      cycles++;
    end
    if (!with_branch && accepts < n_target) begin
      n_checks++; n_fail++; $display("FAIL rand_budget: got %0d fetches want %0d", accepts, n_target);
    end
    freeze = 1'b0; imem_ready = 1'b1;
  endtask

  initial begin : main
    test_reset();
    test_stream();
    test_freeze();
    test_branch_drain();
    test_branch_resp_freeze();
    test_wrap();
    test_random(1'b0, 200, 3000);
    test_random(1'b1, 0, 400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
